// File: rtl/uart_console_pkg.sv
// Shared definitions for the UART console sink and its FIFO.
package uart_console_pkg;

    typedef logic [7:0] uart_ch_t;

    localparam uart_ch_t CH_CR = 8'h0D;
    localparam uart_ch_t CH_LF = 8'h0A;

    localparam int unsigned HIST_BYTES = 16;

    // Ones in the low `len` bytes: selects the pattern bytes that take part in the compare.
    function automatic logic [127:0] pattern_mask(input int unsigned len);
        logic [127:0] m;
        m = '0;
        for (int unsigned i = 0; i < HIST_BYTES; i++) begin
            if (i < len) begin
                m[i*8 +: 8] = '1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and registered level.
module uart_sync_fifo
    import uart_console_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_console_sink.sv
// Bench-side UART console consumer: drops CR, buffers for the printer, counts lines and drops,
// and flags a trailer string seen in the character stream.
module uart_console_sink
    import uart_console_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PAT_LEN = 13,
    parameter logic [127:0] PATTERN = 128'h00000048_49542047_4F4F4420_54524150,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_ch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_ch,
    output logic          match,
    output logic [31:0]   line_count,
    output logic [15:0]   drop_count,
    output logic [LW-1:0] fifo_level
);

    localparam logic [127:0] MASK = pattern_mask(PAT_LEN);

    logic         qual;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push;
    logic         drop;
    logic [127:0] hist;
    logic [127:0] hist_next;
    logic         hit;

    assign qual      = in_valid && (in_ch != CH_CR);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = qual && (!full || pop);
    assign drop      = qual && full && !pop;

    // Compare against the post-shift history so match rises together with the new history.
    assign hist_next = {hist[119:0], in_ch};
    assign hit       = (hist_next & MASK) == (PATTERN & MASK);

    uart_sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (in_ch),
        .dout (out_ch),
        .full (full),
        .empty(empty),
        .level(fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hist       <= '0;
            match      <= 1'b0;
            line_count <= '0;
            drop_count <= '0;
        end else begin
            if (qual) begin
                hist <= hist_next;
                if (hit) begin
                    match <= 1'b1;
                end
                if (in_ch == CH_LF) begin
                    line_count <= line_count + 32'd1;
                end
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/uart_console_sink.md
Name: uart_console_sink

Overview:
- Downstream consumer of the SimTop UART output pair `difftest_uart_out_valid` / `difftest_uart_out_ch`.
- Filters carriage returns and buffers characters in a FIFO. Drains them over a valid/ready stream to the bench console printer.
- Counts lines and drops, and raises a sticky flag when a configured trailer string appears in the character stream (e.g. "HIT GOOD TRAP").
- Sits in the bench between SimTop and the `$write` printer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- PAT_LEN, 13, number of pattern characters compared; 1..16.
- PATTERN, 128'h...("HIT GOOD TRAP"), pattern bytes; the last pattern character is at bits [7:0], the preceding one at [15:8], and so on.

Ports:
- clock  in  1  bench clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  UART character strobe from SimTop; no backpressure exists.
- in_ch  in  8  UART character.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  printer accepts head.
- out_ch  out  8  FIFO head character.
- match  out  1  sticky; pattern seen.
- line_count  out  32  accepted 0x0A characters; wraps modulo 2^32.
- drop_count  out  16  characters lost to a full FIFO; saturates at 16'hFFFF.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - one clock is used; reset is synchronous and active-high.
  - At a clock edge with reset=1, the following are cleared to 0: FIFO pointers, fifo_level, out_valid, match, line_count, drop_count, and the history register.
  - out_ch is don't-care while out_valid=0.
  - in_valid is ignored during reset.
  - Reset asserted mid-operation discards buffered characters.
- Accept:
  - Qualifying input: in_valid=1 and in_ch != 8'h0D. CR characters are discarded entirely: no push, no history update, no count.
- History and match:
  - Every qualifying character shifts into a 16-byte history register (newest at [7:0]). This happens regardless of FIFO state.
  - match sets on the clock after the history's low PAT_LEN bytes equal PATTERN's low PAT_LEN bytes.
  - match is a registered compare, so it is visible 1 cycle after the final pattern character is accepted. It stays 1 until reset.
- line_count:
  - Increments on each qualifying 0x0A, regardless of FIFO drop.
- Push/pop:
  - pop = out_valid & out_ready.
  - push = qualifying & (!full | pop).
  - If qualifying & full & !pop: the character is dropped and drop_count increments (saturating).
- FIFO:
  - First-word-fall-through; out_ch = mem[rd_ptr]; out_valid = (fifo_level != 0).
  - No empty bypass: a character pushed in cycle N is visible on out_valid/out_ch from cycle N+1.
  - Full with simultaneous push and pop: both occur; level is unchanged.
  - Empty with push: level becomes 1 next cycle.
  - Pointers are $clog2(DEPTH) bits plus a wrap bit; full when indices are equal and wrap bits differ.
  - out_ch must hold stable while out_valid=1 and out_ready=0.
- fifo_level is registered and updated by push minus pop each cycle.

Decomposition:
- Shared package `uart_console_pkg`:
  - constants CH_CR=8'h0D, CH_LF=8'h0A
  - typedef uart_ch_t (logic [7:0])
  - function pattern_mask(PAT_LEN) returning a 128-bit byte mask
- One sub-module `uart_sync_fifo` (DEPTH, width 8; push/pop/full/empty/level), reusable for the future UART input feeder.
- Filter, history/match and counters stay in the top.

Test Plan:
- Reset then input "AB\r\nC" with out_ready=1 → out_ch sequence 'A','B',0x0A,'C'; line_count=1; drop_count=0; no CR ever appears on out_ch.
- out_ready=0, 20 qualifying chars at DEPTH=16 → fifo_level=16, drop_count=4. First 16 chars are retained in order; releasing out_ready drains exactly those 16.
- Full FIFO, out_ready=1, qualifying char in the same cycle → push accepted; fifo_level stays 16; drop_count unchanged; new char emerges last.
- Input "xxHIT GOOD TRAP" → match=0 until the cycle after 'P' is accepted, then 1. Subsequent 'Z' input keeps match=1. Input "HIT GOOD TRAQ" never sets match.
- Input "HIT GOOD\rTRAP"-style CR insertion → CR is ignored by history, so "HIT GOOD TRAP" with an embedded CR still sets match. Input "HIT GOOD  TRAP" (extra space) does not.
- 5 chars buffered, then reset asserted for 1 cycle → next cycle: out_valid=0, fifo_level=0, counters=0, match=0. A subsequent 'Q' appears on out_ch one cycle after input.
